button_debouncer: RTL

- Debounces and edge-detects the board push-buttons.
- Uses the slow divided clock from the clock-divider stage as a sample timebase. That signal is treated strictly as data: it is synchronised and edge-detected, and never used as a clock.
- Sits directly downstream of the divider and upstream of the calculator control FSM.
- Outputs a clean level per button plus single-cycle press and release strobes in the system clock domain.

---
 rtl/button_debouncer_if.sv | 27 ++
 rtl/button_debouncer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/button_debouncer_if.sv
// Signal bundle between the button debouncer and its neighbours: the divided
// sample timebase and raw buttons going in, clean levels and strobes coming out.
interface button_debouncer_if #(
  parameter int NUM_BTN = 5
);
  logic               sample_clk;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output sample_clk,
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  sample_clk,
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_debouncer.sv
// Debounces the push-buttons against strobes derived from the divided sample clock,
// which is synchronised and edge-detected as data; emits levels and press/release pulses.
module button_debouncer #(
  parameter int NUM_BTN        = 5,
  parameter int STABLE_SAMPLES = 4
) (
  input logic               clkin,
  input logic               reset,
  button_debouncer_if.slave bus
);
  typedef enum logic [1:0] {IDLE_LOW, PEND_HIGH, IDLE_HIGH, PEND_LOW} state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_SAMPLES);

  logic               s1, s2, s3;
  logic               strobe;
  logic [NUM_BTN-1:0] sb_meta, sb;
  state_t             state      [NUM_BTN];
  state_t             state_next [NUM_BTN];
  logic [3:0]         cnt        [NUM_BTN];
  logic [3:0]         cnt_next   [NUM_BTN];
  logic [NUM_BTN-1:0] level_q, press_q, release_q;
  logic [NUM_BTN-1:0] level_next, rise, fall;

  assign strobe = s2 & ~s3;

  // s3 only remembers the previous s2, so a held sample_clk yields a single strobe.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      sb_meta <= '0;
      sb      <= '0;
    end else begin
      s1      <= bus.sample_clk;
      s2      <= s1;
      s3      <= s2;
      sb_meta <= bus.btn_raw;
      sb      <= sb_meta;
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= IDLE_LOW;
        cnt[i]   <= 4'd0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
      level_q   <= level_next;
      press_q   <= rise;
      release_q <= fall;
    end
  end

  // Each channel only moves on a strobe; a disagreeing sample aborts the pending run.
  always_comb begin
    rise = '0;
    fall = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
      if (strobe) begin
        case (state[i])
          IDLE_LOW: begin
            if (sb[i]) begin
              if (STABLE == 4'd1) begin
                state_next[i] = IDLE_HIGH;
                rise[i]       = 1'b1;
              end else begin
                state_next[i] = PEND_HIGH;
                cnt_next[i]   = 4'd1;
              end
            end
          end
          PEND_HIGH: begin
            if (sb[i]) begin
              if (cnt[i] + 4'd1 == STABLE) begin
                state_next[i] = IDLE_HIGH;
                cnt_next[i]   = 4'd0;
                rise[i]       = 1'b1;
              end else begin
                cnt_next[i] = cnt[i] + 4'd1;
              end
            end else begin
              state_next[i] = IDLE_LOW;
              cnt_next[i]   = 4'd0;
            end
          end
          IDLE_HIGH: begin
            if (!sb[i]) begin
              if (STABLE == 4'd1) begin
                state_next[i] = IDLE_LOW;
                fall[i]       = 1'b1;
              end else begin
                state_next[i] = PEND_LOW;
                cnt_next[i]   = 4'd1;
              end
            end
          end
          PEND_LOW: begin
            if (!sb[i]) begin
              if (cnt[i] + 4'd1 == STABLE) begin
                state_next[i] = IDLE_LOW;
                cnt_next[i]   = 4'd0;
                fall[i]       = 1'b1;
              end else begin
                cnt_next[i] = cnt[i] + 4'd1;
              end
            end else begin
              state_next[i] = IDLE_HIGH;
              cnt_next[i]   = 4'd0;
            end
          end
          default: begin
            state_next[i] = IDLE_LOW;
            cnt_next[i]   = 4'd0;
          end
        endcase
      end
    end
    level_next = (level_q | rise) & ~fall;
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
endmodule
